// File: rtl/rv64i_pkg.sv
// rv64i_pkg: shared encodings, ALU ops and pipeline-register layouts for the RV64I datapath
package rv64i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } alu_op_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } id_ex_t;

    typedef struct packed {
        logic [63:0] alu_res;
        logic [63:0] store_val;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    localparam if_id_t  IF_ID_NOP     = '{pc: 64'd0, instr: NOP};
    localparam id_ex_t  ID_EX_BUBBLE  = '0;
    localparam ex_mem_t EX_MEM_BUBBLE = '0;
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

    function automatic logic [63:0] sext12(input logic [11:0] v);
        return {{52{v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv64i_datapath_imem.sv
// imem: word-addressed instruction ROM loaded externally; fetches past the end return a NOP
module imem
    import rv64i_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic [61:0] word,
    output logic [31:0] instr
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] memory [DEPTH];

    assign instr = (word < 62'(DEPTH)) ? memory[word[AW-1:0]] : NOP;

endmodule

// File: rtl/rv64i_datapath_regfile.sv
// regfile: 32x64 register file, two read ports with write-through bypass, x0 hardwired to zero
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  addr_a,
    input  logic [4:0]  addr_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [63:0] wdata,
    output logic [63:0] data_a,
    output logic [63:0] data_b
);

    logic [63:0] X [32];
    logic        wr_live;

    assign wr_live = we && waddr != 5'd0;

    // Registers clear on reset; x0 is never written so it always reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) X[i] <= '0;
        end else if (wr_live) begin
            X[waddr] <= wdata;
        end
    end

    // A read of the register being written this cycle sees the incoming value
    always_comb begin
        data_a = (wr_live && waddr == addr_a) ? wdata : X[addr_a];
        data_b = (wr_live && waddr == addr_b) ? wdata : X[addr_b];
    end

endmodule

// File: rtl/rv64i_datapath.sv
// rv64i_datapath: five-stage RV64I integer pipeline with forwarding, load-use stall and branch flush
module rv64i_datapath
    import rv64i_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input logic clk,
    input logic rst
);

    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [63:0]    pc;
    logic [31:0]    fetch_instr;
    if_id_t         if_id;
    id_ex_t         id_ex, id_ex_n;
    ex_mem_t        ex_mem, ex_mem_n;
    mem_wb_t        mem_wb, mem_wb_n;
    logic [63:0]    dmem [DMEM_DEPTH];

    logic [6:0]     opcode, funct7;
    logic [2:0]     funct3;
    logic [4:0]     rs1, rs2, rd;
    logic [63:0]    rs1_val, rs2_val;
    logic           is_r, is_addi, is_ld, is_sd, is_beq;
    logic           use_rs1, use_rs2;
    logic           stall, taken;
    logic [63:0]    target;
    logic [63:0]    op_a, op_b_reg, op_b, alu_res;
    logic [DAW-1:0] didx;

    imem #(.DEPTH(IMEM_DEPTH)) IMEM (
        .word  (pc[63:2]),
        .instr (fetch_instr)
    );

    assign {funct7, rs2, rs1, funct3, rd, opcode} = if_id.instr;

    regfile REGFILE (
        .clk    (clk),
        .rst    (rst),
        .addr_a (rs1),
        .addr_b (rs2),
        .we     (mem_wb.reg_write),
        .waddr  (mem_wb.rd),
        .wdata  (mem_wb.result),
        .data_a (rs1_val),
        .data_b (rs2_val)
    );

    // Decode: unsupported encodings become bubbles; unused source fields are zeroed so they never match a hazard
    always_comb begin
        is_r    = opcode == OP_R && ((funct7 == F7_BASE && funct3 inside {F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND})
                                  || (funct7 == F7_SUB && funct3 == F3_ADD));
        is_addi = opcode == OP_IMM && funct3 == F3_ADD;
        is_ld   = opcode == OP_LOAD && funct3 == F3_D;
        is_sd   = opcode == OP_STORE && funct3 == F3_D;
        is_beq  = opcode == OP_BRANCH && funct3 == F3_BEQ;
        use_rs1 = is_r || is_addi || is_ld || is_sd || is_beq;
        use_rs2 = is_r || is_sd || is_beq;
        id_ex_n           = ID_EX_BUBBLE;
        id_ex_n.pc        = if_id.pc;
        id_ex_n.rs1_val   = rs1_val;
        id_ex_n.rs2_val   = rs2_val;
        id_ex_n.rs1       = use_rs1 ? rs1 : 5'd0;
        id_ex_n.rs2       = use_rs2 ? rs2 : 5'd0;
        id_ex_n.rd        = (is_r || is_addi || is_ld) ? rd : 5'd0;
        id_ex_n.imm       = is_sd  ? sext12({funct7, rd}) :
                            is_beq ? {{51{if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
                                      if_id.instr[30:25], if_id.instr[11:8], 1'b0} :
                                     sext12(if_id.instr[31:20]);
        id_ex_n.alu_op    = !is_r              ? ALU_ADD :
                            funct7 == F7_SUB   ? ALU_SUB :
                            funct3 == F3_SLT   ? ALU_SLT :
                            funct3 == F3_XOR   ? ALU_XOR :
                            funct3 == F3_OR    ? ALU_OR  :
                            funct3 == F3_AND   ? ALU_AND : ALU_ADD;
        id_ex_n.use_imm   = is_addi || is_ld || is_sd;
        id_ex_n.reg_write = is_r || is_addi || is_ld;
        id_ex_n.mem_read  = is_ld;
        id_ex_n.mem_write = is_sd;
        id_ex_n.branch    = is_beq;
    end

    assign stall = id_ex.mem_read && id_ex.rd != 5'd0 &&
                   (id_ex.rd == id_ex_n.rs1 || id_ex.rd == id_ex_n.rs2);

    // Execute: forward the youngest producer (EX/MEM before MEM/WB), compute ALU result and resolve BEQ
    always_comb begin
        op_a     = (id_ex.rs1 != 5'd0 && ex_mem.reg_write && ex_mem.rd == id_ex.rs1) ? ex_mem.alu_res :
                   (id_ex.rs1 != 5'd0 && mem_wb.reg_write && mem_wb.rd == id_ex.rs1) ? mem_wb.result  :
                                                                                      id_ex.rs1_val;
        op_b_reg = (id_ex.rs2 != 5'd0 && ex_mem.reg_write && ex_mem.rd == id_ex.rs2) ? ex_mem.alu_res :
                   (id_ex.rs2 != 5'd0 && mem_wb.reg_write && mem_wb.rd == id_ex.rs2) ? mem_wb.result  :
                                                                                      id_ex.rs2_val;
        op_b     = id_ex.use_imm ? id_ex.imm : op_b_reg;
        alu_res  = id_ex.alu_op == ALU_SUB ? op_a - op_b :
                   id_ex.alu_op == ALU_AND ? op_a & op_b :
                   id_ex.alu_op == ALU_OR  ? op_a | op_b :
                   id_ex.alu_op == ALU_XOR ? op_a ^ op_b :
                   id_ex.alu_op == ALU_SLT ? {63'd0, $signed(op_a) < $signed(op_b)} :
                                             op_a + op_b;
        taken    = id_ex.branch && op_a == op_b_reg;
        target   = id_ex.pc + id_ex.imm;
        ex_mem_n = '{alu_res: alu_res, store_val: op_b_reg, rd: id_ex.rd, reg_write: id_ex.reg_write,
                     mem_read: id_ex.mem_read, mem_write: id_ex.mem_write};
    end

    assign didx = ex_mem.alu_res[DAW+2:3];

    // Memory stage: loads read the doubleword selected by the truncated address
    always_comb begin
        mem_wb_n = '{result: ex_mem.mem_read ? dmem[didx] : ex_mem.alu_res,
                     rd: ex_mem.rd, reg_write: ex_mem.reg_write};
    end

    // Pipeline advance: a taken branch flushes IF/ID and ID/EX; a load-use stall holds PC and IF/ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            if_id  <= IF_ID_NOP;
            id_ex  <= ID_EX_BUBBLE;
            ex_mem <= EX_MEM_BUBBLE;
            mem_wb <= MEM_WB_BUBBLE;
        end else begin
            pc     <= taken ? target : stall ? pc : pc + 64'd4;
            if_id  <= taken ? IF_ID_NOP : stall ? if_id : '{pc: pc, instr: fetch_instr};
            id_ex  <= (taken || stall) ? ID_EX_BUBBLE : id_ex_n;
            ex_mem <= ex_mem_n;
            mem_wb <= mem_wb_n;
        end
    end

    // Data memory: cleared on reset, stores commit as they leave MEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else if (ex_mem.mem_write) begin
            dmem[didx] <= ex_mem.store_val;
        end
    end

endmodule

// File: tb/tb_rv64i_datapath.sv
// tb_rv64i_datapath: directed and random programs checked against an instruction-level reference interpreter
module tb_rv64i_datapath;

    localparam int IMEM_DEPTH = 256;
    localparam int DMEM_DEPTH = 256;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   holds = 0;

    logic [31:0] prog [$];
    logic [63:0] m_x [32];
    logic [63:0] m_mem [DMEM_DEPTH];

    rv64i_datapath #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input int rd, input int r1, input int r2);
        return {f7, 5'(r2), 5'(r1), f3, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_addi(input int rd, input int r1, input int imm);
        return {12'(imm), 5'(r1), 3'd0, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] enc_ld(input int rd, input int r1, input int imm);
        return {12'(imm), 5'(r1), 3'd3, 5'(rd), 7'h03};
    endfunction

    function automatic logic [31:0] enc_sd(input int r2, input int r1, input int imm);
        logic [11:0] v;
        v = 12'(imm);
        return {v[11:5], 5'(r2), 5'(r1), 3'd3, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_beq(input int r1, input int r2, input int off);
        logic [12:0] v;
        v = 13'(off);
        return {v[12], v[10:5], 5'(r2), 5'(r1), 3'd0, v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr(input bit alu_only);
        int k, rd, r1, r2, base, off;
        k    = alu_only ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 11));
        rd   = $urandom_range(0, 7);
        r1   = $urandom_range(0, 7);
        r2   = $urandom_range(0, 7);
        base = $urandom_range(0, 1) ? 0 : r1;
        off  = 8 * int'($urandom_range(0, 5)) + ($urandom_range(0, 3) == 0 ? 3 : 0);
        case (k)
            0:       return enc_addi(rd, r1, int'($urandom_range(0, 4095)) - 2048);
            1:       return enc_r(7'h00, 3'd0, rd, r1, r2);
            2:       return enc_r(7'h20, 3'd0, rd, r1, r2);
            3:       return enc_r(7'h00, 3'd7, rd, r1, r2);
            4:       return enc_r(7'h00, 3'd6, rd, r1, r2);
            5:       return enc_r(7'h00, 3'd4, rd, r1, r2);
            6:       return enc_r(7'h00, 3'd2, rd, r1, r2);
            7:       return enc_ld(rd, base, off);
            8:       return enc_sd(r2, base, off);
            9:       return enc_beq(r1 % 4, r2 % 4, 4 * int'($urandom_range(1, 4)));
            10:      return enc_r(7'h00, 3'd1, rd, r1, r2);
            default: return {20'($urandom), 5'(rd), 7'h37};
        endcase
    endfunction

    // Sequential ISA interpreter: one instruction at a time, no notion of pipeline
    task automatic run_model();
        longint unsigned pc;
        int steps;
        pc = 0;
        steps = 0;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
        for (int i = 0; i < DMEM_DEPTH; i++) m_mem[i] = '0;
        while (pc / 4 < longint'(prog.size()) && steps < 1000) begin
            logic [31:0] w;
            longint a, b, ii, si, bi, res;
            longint unsigned ea;
            bit wr;
            w   = prog[pc / 4];
            a   = m_x[w[19:15]];
            b   = m_x[w[24:20]];
            ii  = $signed(w[31:20]);
            si  = $signed({w[31:25], w[11:7]});
            bi  = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            wr  = 0;
            res = 0;
            pc  = pc + 4;
            case (w[6:0])
                7'h33: begin
                    wr = 1;
                    case ({w[31:25], w[14:12]})
                        {7'h00, 3'd0}: res = a + b;
                        {7'h20, 3'd0}: res = a - b;
                        {7'h00, 3'd7}: res = a & b;
                        {7'h00, 3'd6}: res = a | b;
                        {7'h00, 3'd4}: res = a ^ b;
                        {7'h00, 3'd2}: res = (a < b) ? 1 : 0;
                        default:       wr = 0;
                    endcase
                end
                7'h13: if (w[14:12] == 3'd0) begin wr = 1; res = a + ii; end
                7'h03: if (w[14:12] == 3'd3) begin
                    ea  = a + ii;
                    wr  = 1;
                    res = m_mem[(ea >> 3) % DMEM_DEPTH];
                end
                7'h23: if (w[14:12] == 3'd3) begin
                    ea = a + si;
                    m_mem[(ea >> 3) % DMEM_DEPTH] = b;
                end
                7'h63: if (w[14:12] == 3'd0 && a == b) pc = pc - 4 + bi;
                default: ;
            endcase
            if (wr && w[11:7] != 5'd0) m_x[w[11:7]] = res;
            steps++;
        end
    endtask

    task automatic start();
        rst = 1'b1;
        for (int i = 0; i < IMEM_DEPTH; i++) dut.IMEM.memory[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
        @(negedge clk);
        rst = 1'b0;
        holds = 0;
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            logic [63:0] p;
            p = dut.pc;
            @(negedge clk);
            if (dut.pc == p) holds++;
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s x%0d", tag, i), dut.REGFILE.X[i], m_x[i]);
        for (int i = 0; i < DMEM_DEPTH; i++) check($sformatf("%s mem%0d", tag, i), dut.dmem[i], m_mem[i]);
    endtask

    task automatic load_forwarding();
        prog.delete();
        prog.push_back(enc_addi(1, 0, 5));
        prog.push_back(enc_addi(2, 0, 6));
        prog.push_back(enc_r(7'h00, 3'd0, 4, 1, 2));
        prog.push_back(enc_addi(3, 4, 1));
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("reset pc", dut.pc, 64'd0);
        check("reset x1", dut.REGFILE.X[1], 64'd0);

        load_forwarding();
        start();
        step(4);
        check("latency x1 before edge5", dut.REGFILE.X[1], 64'd0);
        step(1);
        check("latency x1 at edge5", dut.REGFILE.X[1], 64'd5);
        step(10);
        check("fwd x4", dut.REGFILE.X[4], 64'd11);
        check("fwd x3", dut.REGFILE.X[3], 64'd12);
        check("fwd holds", 64'(holds), 64'd0);

        prog.delete();
        prog.push_back(enc_addi(1, 0, 1));
        prog.push_back(enc_r(7'h20, 3'd0, 4, 0, 1));
        start();
        step(15);
        check("neg x4", dut.REGFILE.X[4], ONES);

        prog.delete();
        prog.push_back(enc_addi(1, 0, -1));
        prog.push_back(enc_sd(1, 0, 8));
        prog.push_back(enc_ld(2, 0, 8));
        prog.push_back(enc_r(7'h00, 3'd0, 5, 2, 0));
        start();
        step(15);
        check("loaduse x2", dut.REGFILE.X[2], ONES);
        check("loaduse x5", dut.REGFILE.X[5], ONES);
        check("loaduse mem1", dut.dmem[1], ONES);
        check("loaduse holds", 64'(holds), 64'd1);

        prog.delete();
        prog.push_back(enc_addi(1, 0, 8));
        prog.push_back(enc_addi(2, 0, 9));
        prog.push_back(enc_beq(0, 0, 12));
        prog.push_back(enc_addi(1, 0, 1));
        prog.push_back(enc_addi(2, 0, 1));
        prog.push_back(32'h0000_0013);
        start();
        step(15);
        check("branch x1", dut.REGFILE.X[1], 64'd8);
        check("branch x2", dut.REGFILE.X[2], 64'd9);
        check("branch holds", 64'(holds), 64'd0);

        prog.delete();
        prog.push_back(enc_addi(6, 0, 3));
        prog.push_back(enc_addi(0, 0, 7));
        prog.push_back(enc_r(7'h00, 3'd0, 6, 0, 0));
        start();
        step(15);
        check("x0 x0", dut.REGFILE.X[0], 64'd0);
        check("x0 x6", dut.REGFILE.X[6], 64'd0);

        load_forwarding();
        start();
        step(7);
        check("midrun x1 before reset", dut.REGFILE.X[1], 64'd5);
        #2 rst = 1'b1;
        #1;
        check("midrun pc", dut.pc, 64'd0);
        for (int i = 0; i < 32; i++) check($sformatf("midrun x%0d", i), dut.REGFILE.X[i], 64'd0);
        start();
        step(15);
        check("rerun x4", dut.REGFILE.X[4], 64'd11);
        check("rerun x3", dut.REGFILE.X[3], 64'd12);

        for (int t = 0; t < 20; t++) begin
            bit alu_only;
            int len;
            alu_only = t < 4;
            len = alu_only ? 8 : 24;
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(rand_instr(alu_only));
            run_model();
            start();
            step(alu_only ? 15 : len * 3 + 20);
            check_state($sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv64i_datapath.md
# rv64i_datapath

Five-stage in-order RV64I integer pipeline (IF/ID/EX/MEM/WB) with forwarding, load-use stall and branch flush. It has no external data ports. It fetches from an internal instruction memory that is preloaded by hierarchical `$readmemh` into `IMEM.memory`. Architectural state is observed through the register-file instance `REGFILE.X`. It is the core datapath of the processor top level.

## Interface
- Parameters:
  - `IMEM_DEPTH`, default 256: number of 32-bit instruction words.
  - `DMEM_DEPTH`, default 256: number of 64-bit data doublewords.
- Ports:
  - `clk`  input  1  single clock; all state updates on the rising edge.
  - `rst`  input  1  reset; asynchronous, active-high.
- Hierarchy contract:
  - Instance `IMEM` holds `logic [31:0] memory [IMEM_DEPTH]`.
  - Instance `REGFILE` holds `logic [63:0] X [32]`.

## Operation
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLT.
  - I-type: ADDI.
  - LD and SD.
  - BEQ.
  - Any other opcode executes as a NOP.
- All arithmetic is 64-bit two's complement and wraps on overflow.
- Immediates are sign-extended to 64 bits.
- SLT is a signed compare that writes 1 or 0.
- `x0` reads 0 and ignores writes.
- Fetch:
  - Instruction = `IMEM.memory[PC[ ..:2]]`.
  - Next PC = PC+4 unless a branch is taken.
  - A PC beyond the memory returns a NOP (0x00000013).
- Data memory: 64-bit words indexed by `addr[..:3]`. Misaligned addresses are truncated, with no trap.
- Register file:
  - 2 read ports, 1 write port.
  - The write occurs at the WB rising edge.
  - A same-cycle read of the register being written returns the new value (write-through bypass).
- Forwarding into the EX operands, priority EX/MEM over MEM/WB. The `rs`=x0 operand is never forwarded.
- Load-use hazard (ID source register matches the EX load destination):
  - Hold PC and IF/ID for one cycle.
  - Insert a bubble into ID/EX.
- BEQ:
  - Resolved in EX.
  - Target = branch PC + sign-extended immediate.
  - If taken: redirect PC and flush IF/ID and ID/EX (2-cycle penalty).
- A bubble or flushed instruction has all write/mem-write enables forced to 0.

## Timing
- Reset (asynchronous assertion; release sampled at the next rising edge):
  - PC = 0.
  - All pipeline registers are cleared to NOP.
  - All 32 registers are cleared to 0.
  - Data memory is cleared to 0.
  - IMEM is not affected by reset.
- Reset mid-program: execution restarts at PC 0 on the first edge after release, with cleared register state.
- Latency: the instruction fetched in cycle n (n = 1 at the first edge after release) writes its register at the rising edge ending cycle n+4. There is no stall for ALU chains.
- A load followed by a dependent instruction costs 1 extra cycle.
- A taken branch costs 2 extra cycles. A not-taken branch costs 0.
- Steady state: 1 instruction per cycle. 15 cycles after reset release, a straight-line 8-instruction program has fully retired.

## Structure
- Shared package `rv64i_pkg` contains:
  - Opcode, funct3 and funct7 constants.
  - ALU-op enum.
  - The NOP encoding.
  - Pipeline-register structs (`if_id_t`, `id_ex_t`, `ex_mem_t`, `mem_wb_t`).
- Sub-modules:
  - `regfile`, instance `REGFILE`, contains the array `X`.
  - `imem`, instance `IMEM`, contains the array `memory`.
- Decode, ALU, forwarding, hazard and data-memory logic live inline in the datapath.

## Test plan
- Forwarding:
  - Program: `addi x1,x0,5`; `addi x2,x0,6`; `add x4,x1,x2`; `addi x3,x4,1`.
  - 15 cycles after reset: `X[4]`=11 and `X[3]`=12.
- Negative result: `addi x1,x0,1`; `sub x4,x0,x1` → `X[4]`=64'hFFFF_FFFF_FFFF_FFFF.
- Load-use:
  - Program: `addi x1,x0,-1`; `sd x1,8(x0)`; `ld x2,8(x0)`; `add x5,x2,x0`.
  - Result: `X[2]`=`X[5]`=all-ones.
  - The stall bubble is visible (PC held for 1 cycle).
- Branch flush:
  - Program: `addi x1,x0,8`; `addi x2,x0,9`; `beq x0,x0,+12`; `addi x1,x0,1`; `addi x2,x0,1`; nop.
  - Result: `X[1]`=8 and `X[2]`=9; the squashed writes never occur.
- `x0` protection: `addi x0,x0,7`; `add x6,x0,x0` → `X[0]`=0 and `X[6]`=0.
- Reset mid-run:
  - Assert `rst` asynchronously mid-program: PC=0 and `X[*]`=0 immediately.
  - After release, rerunning the forwarding test gives the same results.
